// File: rtl/pid_pkg.sv
// Shared definitions for the sequential PID core: FSM state encoding and
// default datapath widths.
package pid_pkg;

    localparam int DEF_DW   = 8;
    localparam int DEF_KW   = 8;
    localparam int DEF_IW   = 16;
    localparam int DEF_FRAC = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL_P,
        ST_MUL_I,
        ST_MUL_D,
        ST_SUM
    } pid_state_e;

endpackage

// File: rtl/pid_sat.sv
// Signed saturating narrower: clamps an IN_W-bit value into the signed
// OUT_W-bit range and flags when clamping happened.
module pid_sat #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);

    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        dout = din[OUT_W-1:0];
        sat  = 1'b0;
        if (din > MAX_V) begin
            dout = MAX_V[OUT_W-1:0];
            sat  = 1'b1;
        end else if (din < MIN_V) begin
            dout = MIN_V[OUT_W-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/pid_seq_core.sv
// Sequential PID controller: one shared signed multiplier evaluates the P, I
// and D terms over three cycles, then a SUM cycle scales, clamps and commits.
module pid_seq_core
    import pid_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int KW   = DEF_KW,
    parameter int IW   = DEF_IW,
    parameter int FRAC = DEF_FRAC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 e_valid,
    input  logic signed [DW-1:0] e,
    input  logic [KW-1:0]        kp,
    input  logic [KW-1:0]        ki,
    input  logic [KW-1:0]        kd,
    input  logic                 clr,
    output logic                 busy,
    output logic                 u_valid,
    output logic signed [DW-1:0] u,
    output logic                 sat,
    output logic                 overrun
);

    localparam int SW = KW + IW + 3;
    localparam int PW = KW + IW + 1;

    pid_state_e state, state_nxt;

    logic signed [DW-1:0] e_r, e_prev;
    logic [KW-1:0]        kp_r, ki_r, kd_r;
    logic signed [DW:0]   de_r, de_w;
    logic signed [IW-1:0] acc, acc_next_r, acc_next_w;
    logic signed [IW:0]   acc_sum_w;
    logic                 acc_sat_unused;
    logic signed [SW-1:0] sum, y;
    logic signed [DW-1:0] u_w;
    logic                 sat_w;
    logic signed [KW:0]   mul_a;
    logic signed [IW-1:0] mul_b;
    logic signed [PW-1:0] prod;
    logic                 accept, e_pos, windup_hold;

    assign busy   = (state != ST_IDLE);
    assign accept = ena & e_valid & ~clr & (state == ST_IDLE);

    assign de_w      = (DW+1)'(e) - (DW+1)'(e_prev);
    assign acc_sum_w = (IW+1)'(acc) + (IW+1)'(e);

    pid_sat #(.IN_W(IW+1), .OUT_W(IW)) u_acc_sat (
        .din  (acc_sum_w),
        .dout (acc_next_w),
        .sat  (acc_sat_unused)
    );

    // Single multiplier: gains are zero-extended so the product stays signed.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            ST_MUL_P: begin mul_a = {1'b0, kp_r}; mul_b = IW'(e_r);      end
            ST_MUL_I: begin mul_a = {1'b0, ki_r}; mul_b = acc_next_r;    end
            ST_MUL_D: begin mul_a = {1'b0, kd_r}; mul_b = IW'(de_r);     end
            default:  ;
        endcase
    end

    assign prod = PW'(mul_a) * PW'(mul_b);
    assign y    = sum >>> FRAC;

    pid_sat #(.IN_W(SW), .OUT_W(DW)) u_out_sat (
        .din  (y),
        .dout (u_w),
        .sat  (sat_w)
    );

    // Anti-windup: freeze the integrator when the error pushes further into the clamp.
    assign e_pos       = ~e_r[DW-1] & (|e_r);
    assign windup_hold = sat_w & ((~y[SW-1] & e_pos) | (y[SW-1] & e_r[DW-1]));

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ST_IDLE;
        end else if (ena) begin
            case (state)
                ST_IDLE:  if (e_valid) state_nxt = ST_MUL_P;
                ST_MUL_P: state_nxt = ST_MUL_I;
                ST_MUL_I: state_nxt = ST_MUL_D;
                ST_MUL_D: state_nxt = ST_SUM;
                ST_SUM:   state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: datapath registers are reset too, so an aborted computation leaves no stale operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_r        <= '0;
            e_prev     <= '0;
            kp_r       <= '0;
            ki_r       <= '0;
            kd_r       <= '0;
            de_r       <= '0;
            acc        <= '0;
            acc_next_r <= '0;
            sum        <= '0;
            u          <= '0;
            sat        <= 1'b0;
            u_valid    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            u_valid <= 1'b0;
            overrun <= 1'b0;
            if (clr) begin
                acc    <= '0;
                e_prev <= '0;
            end else if (ena) begin
                overrun <= e_valid & busy;
                if (accept) begin
                    e_r        <= e;
                    kp_r       <= kp;
                    ki_r       <= ki;
                    kd_r       <= kd;
                    de_r       <= de_w;
                    acc_next_r <= acc_next_w;
                end
                case (state)
                    ST_MUL_P:           sum <= SW'(prod);
                    ST_MUL_I, ST_MUL_D: sum <= sum + SW'(prod);
                    ST_SUM: begin
                        u       <= u_w;
                        sat     <= sat_w;
                        e_prev  <= e_r;
                        u_valid <= 1'b1;
                        if (!windup_hold) acc <= acc_next_r;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
